// File: rtl/dffrs_pipe_pkg.sv
// rtl/dffrs_pipe_pkg.sv - shared constants and sizing helper for the dffrs_pipe slice
package dffrs_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 3;

   function automatic int occ_width(input int depth);
      int w;
      w = $clog2(depth + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dffrs_pipe_if.sv
// rtl/dffrs_pipe_if.sv - upstream/downstream valid/ready bundle for dffrs_pipe
// master drives words in and accepts them out; slave is the pipe itself.
interface dffrs_pipe_if
   import dffrs_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/dffrs_pipe_stage.sv
// rtl/dffrs_pipe_stage.sv - one pipe stage: valid flag plus reset/preset data register
// Preset port and SET_VAL exist only with DFFRS_PIPE_SET_EN.
module dffrs_stage
   import dffrs_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef DFFRS_PIPE_SET_EN
   ,
   parameter logic [WIDTH-1:0] SET_VAL   = '1
`endif
) (
   input  logic             clk,
   input  logic             R,
`ifdef DFFRS_PIPE_SET_EN
   input  logic             S,
`endif
   input  logic             i_load,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);
   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Empty upstream slots clear the flag but leave the data register alone.
   always_ff @(posedge clk) begin
      if (R) begin
         r_valid <= 1'b0;
         r_data  <= RESET_VAL;
      end
`ifdef DFFRS_PIPE_SET_EN
      else if (S) begin
         r_data <= SET_VAL;
      end
`endif
      else if (i_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
endmodule

// File: rtl/dffrs_pipe.sv
// rtl/dffrs_pipe.sv - WIDTH x DEPTH valid/ready pipeline of reset/set stages with bubble collapse
// Preset (S port, SET_VAL) is built only with DFFRS_PIPE_SET_EN.
module dffrs_pipe
   import dffrs_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               DEPTH     = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef DFFRS_PIPE_SET_EN
   ,
   parameter logic [WIDTH-1:0] SET_VAL   = '1
`endif
) (
   input  logic                          clk,
   input  logic                          R,
`ifdef DFFRS_PIPE_SET_EN
   input  logic                          S,
`endif
   dffrs_pipe_if.slave                   bus,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);
   localparam int OCC_W = occ_width(DEPTH);

   logic             w_set;
   logic             w_rdy  [DEPTH+1];
   logic             w_v    [DEPTH];
   logic             w_up_v [DEPTH];
   logic [WIDTH-1:0] w_d    [DEPTH];
   logic [WIDTH-1:0] w_up_d [DEPTH];
   logic             w_in_hs;
   logic             w_out_hs;
   logic [OCC_W-1:0] r_occ;

`ifdef DFFRS_PIPE_SET_EN
   assign w_set = S;
`else
   assign w_set = 1'b0;
`endif

   assign w_rdy[DEPTH] = bus.out_ready;

   // A stage may load whenever it is empty or its word is moving on.
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      assign w_rdy[g] = !w_v[g] || w_rdy[g+1];

      if (g == 0) begin : g_first
         assign w_up_v[g] = bus.in_valid;
         assign w_up_d[g] = bus.in_data;
      end else begin : g_rest
         assign w_up_v[g] = w_v[g-1];
         assign w_up_d[g] = w_d[g-1];
      end

      dffrs_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
`ifdef DFFRS_PIPE_SET_EN
         ,
         .SET_VAL   (SET_VAL)
`endif
      ) u_stage (
         .clk     (clk),
         .R       (R),
`ifdef DFFRS_PIPE_SET_EN
         .S       (S),
`endif
         .i_load  (w_rdy[g]),
         .i_valid (w_up_v[g]),
         .i_data  (w_up_d[g]),
         .o_valid (w_v[g]),
         .o_data  (w_d[g])
      );
   end

   assign bus.in_ready  = w_rdy[0] && !w_set;
   assign bus.out_valid = w_v[DEPTH-1] && !w_set;
   assign bus.out_data  = w_d[DEPTH-1];

   assign w_in_hs  = bus.in_valid && bus.in_ready;
   assign w_out_hs = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (R) begin
         r_occ <= '0;
      end else if (w_in_hs && !w_out_hs) begin
         r_occ <= r_occ + OCC_W'(1);
      end else if (!w_in_hs && w_out_hs) begin
         r_occ <= r_occ - OCC_W'(1);
      end
   end

   assign occupancy = r_occ;
endmodule

// File: tb/tb_dffrs_pipe.sv
// tb/tb_dffrs_pipe.sv - scoreboard bench for dffrs_pipe (preset cases need DFFRS_PIPE_SET_EN)
module tb_dffrs_pipe;
   import dffrs_pkg::*;

   localparam int         WIDTH = 8;
   localparam int         DEPTH = 3;
   localparam logic [7:0] RST_V = 8'h00;
   localparam logic [7:0] SET_V = 8'hFF;

   typedef struct {
      logic [7:0] data;
      int         t;
   } word_t;

   logic                        clk = 1'b0;
   logic                        R;
   logic                        S;
   logic [occ_width(DEPTH)-1:0] occupancy;
   int                          n_vec = 0;
   int                          n_err = 0;
   int                          cyc = 0;
   bit                          mon_en = 1'b0;
   word_t                       sb_q[$];

   dffrs_pipe_if #(.WIDTH(WIDTH)) bus ();

   dffrs_pipe #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .RESET_VAL (RST_V)
`ifdef DFFRS_PIPE_SET_EN
      ,
      .SET_VAL   (SET_V)
`endif
   ) dut (
      .clk       (clk),
      .R         (R),
`ifdef DFFRS_PIPE_SET_EN
      .S         (S),
`endif
      .bus       (bus),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   // Reference: in-flight words in order; the pipe blocks only when all DEPTH slots are full.
   always @(negedge clk) begin
      word_t w;
      bit    exp_rdy;
      if (mon_en) begin
         chk("occupancy", 32'(occupancy), 32'(sb_q.size()));
         if (R) begin
            sb_q.delete();
         end else begin
            exp_rdy = !S && ((sb_q.size() < DEPTH) || bus.out_ready);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (S) chk("out_valid_gated", 32'(bus.out_valid), 32'd0);
            if (sb_q.size() == 0) begin
               chk("no_stale_out", 32'(bus.out_valid), 32'd0);
            end else if (bus.out_valid && bus.out_ready) begin
               w = sb_q.pop_front();
               chk("out_data", 32'(bus.out_data), 32'(w.data));
               chk("latency_min", 32'((cyc - w.t) >= DEPTH), 32'd1);
            end
            if (S) foreach (sb_q[i]) sb_q[i].data = SET_V;
            if (bus.in_valid && bus.in_ready) sb_q.push_back('{data: bus.in_data, t: cyc});
         end
      end
   end

   logic [7:0] lat_tab [4];

   initial begin
      lat_tab = '{8'hA5, 8'h01, 8'h02, 8'h03};
      R = 1'b1;
      S = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h3C;
      bus.out_ready = 1'b0;

      // reset held two cycles with a word offered
      @(posedge clk);
      mon_en = 1'b1;
      #2;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'(RST_V));
      chk("rst_occ", 32'(occupancy), 32'd0);
      next();
      R = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      next();

      // latency and throughput
      bus.out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus.in_valid = (k < 4);
         bus.in_data  = (k < 4) ? lat_tab[k] : 8'h00;
         @(negedge clk);
         if (k >= 3) begin
            chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
            chk("lat_out_data", 32'(bus.out_data), 32'(lat_tab[k-3]));
         end else begin
            chk("lat_out_empty", 32'(bus.out_valid), 32'd0);
         end
         if (k == 3) chk("lat_occ_peak", 32'(occupancy), 32'd3);
         next();
      end

      // backpressure
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hB0 + 8'(k);
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'(k < 3));
         chk("bp_occ", 32'(occupancy), 32'(k));
         next();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume_ready", 32'(bus.in_ready), 32'd1);
      next();
      bus.in_valid = 1'b0;
      repeat (5) next();
      @(negedge clk);
      chk("bp_drained", 32'(occupancy), 32'd0);
      next();

      // bubble collapse
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h11;
      next();
      bus.in_valid  = 1'b0;
      next();
      next();
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h22;
      next();
      bus.in_valid  = 1'b0;
      next();
      @(negedge clk);
      chk("bub_occ", 32'(occupancy), 32'd2);
      chk("bub_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bub_out_data", 32'(bus.out_data), 32'h11);
      chk("bub_in_ready", 32'(bus.in_ready), 32'd1);
      next();

`ifdef DFFRS_PIPE_SET_EN
      // preset with two words held
      S = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h77;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("pre_in_ready", 32'(bus.in_ready), 32'd0);
      chk("pre_out_valid", 32'(bus.out_valid), 32'd0);
      next();
      S = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("pre_out_data", 32'(bus.out_data), 32'(SET_V));
      chk("pre_occ", 32'(occupancy), 32'd2);
      next();
`endif
      bus.out_ready = 1'b1;
      repeat (4) next();

      // R and S together with three words in flight
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hC1 + 8'(k);
         next();
      end
      R = 1'b1;
      S = 1'b1;
      bus.in_data   = 8'hC4;
      bus.out_ready = 1'b1;
      next();
      R = 1'b0;
      S = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("pri_out_data", 32'(bus.out_data), 32'(RST_V));
      chk("pri_occ", 32'(occupancy), 32'd0);
      chk("pri_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (5) next();

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = 8'($urandom);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         R = ($urandom_range(0, 59) == 0);
`ifdef DFFRS_PIPE_SET_EN
         S = ($urandom_range(0, 29) == 0);
`endif
         next();
      end
      R = 1'b0;
      S = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) next();
      @(negedge clk);
      chk("final_occ", 32'(occupancy), 32'd0);
      chk("final_out_valid", 32'(bus.out_valid), 32'd0);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
